s16x4_bus_arbiter: RTL and testbench
====================================

S16X4_BUS_ARBITER -- requirements
Module: s16x4_bus_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 15: count of stalled strobed cycles on the granted master before an error pulse; legal range 1..255.
REQ-002 clk_i  in  1  single system clock; all state changes on rising edge.
REQ-003 res_i  in  1  reset; asynchronous, active-low.
REQ-004 m0_adr_i  in  15  CPU word address [15:1]; m0_we_i in 1; m0_cyc_i in 1; m0_stb_i in 2 (byte lanes); m0_dat_i in 16 (write data).
REQ-005 m0_ack_o  out 1  CPU acknowledge; m0_err_o out 1 CPU timeout error; m0_dat_o out 16 CPU read data.
REQ-006 m1_adr_i  in  15; m1_we_i in 1; m1_cyc_i in 1; m1_stb_i in 2; m1_dat_i in 16: second master (DMA/video fetcher), same meanings as m0.
REQ-007 m1_ack_o  out 1; m1_err_o out 1; m1_dat_o out 16: second master responses.
REQ-008 s_adr_o out 15; s_we_o out 1; s_cyc_o out 1; s_stb_o out 2; s_dat_o out 16: shared slave bus.
REQ-009 s_ack_i in 1; s_dat_i in 16: shared slave responses.
REQ-010 gnt_o  out 2  current owner, one-hot (01 = m0, 10 = m1, 00 = none).

Function
REQ-011 States: IDLE, OWN0, OWN1; gnt_o SHALL be 00/01/10 respectively, decoded from registered state only.
REQ-012 IDLE: s_cyc_o=0, s_stb_o=00, s_we_o=0, s_adr_o=0, s_dat_o=0; no master acked.
REQ-013 IDLE -> OWN0 if m0_cyc_i only; -> OWN1 if m1_cyc_i only; both: grant master not in last-owner bit; neither: stay.
REQ-014 Arbitration latency: exactly one clock from cyc assertion in IDLE to grant; first slave cycle visible the cycle after.
REQ-015 OWNx: s_adr/we/cyc/stb/dat_o SHALL combinationally equal master x inputs; grant held while mx_cyc_i=1 regardless of other requests.
REQ-016 OWNx with mx_cyc_i=0: -> other owner if its cyc=1 (direct handover, no IDLE cycle), else IDLE; last-owner bit := x.
REQ-017 mx_ack_o = s_ack_i & owner==x & mx_cyc_i; non-owner ack=0 and err=0 (non-owner stalls).
REQ-018 m0_dat_o and m1_dat_o SHALL both equal s_dat_i (broadcast); only ack qualifies it.
REQ-019 Stall counter, 8 bits: increments each cycle owner has cyc=1, stb!=00, s_ack_i=0; clears on s_ack_i, on stb=00, on owner change.
REQ-020 Counter reaching TIMEOUT: owner err_o=1 for exactly one cycle, counter clears that edge; ack suppressed to owner in that cycle even if s_ack_i=1.
REQ-021 err does not revoke grant; owner must drop cyc to release.
REQ-022 Simultaneous owner cyc drop and s_ack_i: ack still routed to owner that cycle (combinational), state moves per REQ-016 next edge.
REQ-023 stb_i of 00 with cyc=1 is a held-bus idle cycle: grant kept, no counting, no err.

Reset
REQ-024 res_i=0 asynchronously forces IDLE, gnt_o=00, counter=0, last-owner=m1 (so m0 wins first contention), all ack/err=0, s_cyc_o=0.
REQ-025 Reset asserted mid-transfer SHALL drop s_cyc_o immediately without waiting for s_ack_i; after release, arbitration restarts per REQ-013.

Verification
REQ-026 Reset release, both cyc=1 same cycle -> gnt_o=01 after one edge; s_adr_o=m0_adr_i (e.g. 7FF8), m1_ack_o=0 throughout.
REQ-027 m0 owns, s_ack_i=1 each cycle for 3 cycles, m0 drops cyc with m1 waiting -> next edge gnt_o=10, no IDLE cycle; then m1 drops, both request -> gnt_o=01.
REQ-028 m1 owns, s_ack_i held 0, stb=11 -> m1_err_o pulses 1 for one cycle after TIMEOUT (15) stalled cycles, gnt_o stays 10 until m1 drops cyc.
REQ-029 m0 owns, stb=00 for 20 cycles with cyc=1 -> no err, gnt_o remains 01, s_cyc_o=1.
REQ-030 res_i pulsed low mid-OWN1 with s_ack_i=0 -> same-cycle s_cyc_o=0, gnt_o=00; after release with only m1_cyc=1 -> gnt_o=10 one edge later.

Source files
------------

// File: rtl/s16x4_bus_arbiter_if.sv
// Bundle of the two 16-bit master ports, the shared slave port and the grant vector.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface s16x4_bus_arbiter_if;
    logic [14:0] m0_adr_i;
    logic        m0_we_i;
    logic        m0_cyc_i;
    logic [1:0]  m0_stb_i;
    logic [15:0] m0_dat_i;
    logic        m0_ack_o;
    logic        m0_err_o;
    logic [15:0] m0_dat_o;

    logic [14:0] m1_adr_i;
    logic        m1_we_i;
    logic        m1_cyc_i;
    logic [1:0]  m1_stb_i;
    logic [15:0] m1_dat_i;
    logic        m1_ack_o;
    logic        m1_err_o;
    logic [15:0] m1_dat_o;

    logic [14:0] s_adr_o;
    logic        s_we_o;
    logic        s_cyc_o;
    logic [1:0]  s_stb_o;
    logic [15:0] s_dat_o;
    logic        s_ack_i;
    logic [15:0] s_dat_i;

    logic [1:0]  gnt_o;

    modport slave (
        input  m0_adr_i, m0_we_i, m0_cyc_i, m0_stb_i, m0_dat_i,
        output m0_ack_o, m0_err_o, m0_dat_o,
        input  m1_adr_i, m1_we_i, m1_cyc_i, m1_stb_i, m1_dat_i,
        output m1_ack_o, m1_err_o, m1_dat_o,
        output s_adr_o, s_we_o, s_cyc_o, s_stb_o, s_dat_o,
        input  s_ack_i, s_dat_i,
        output gnt_o
    );

    modport master (
        output m0_adr_i, m0_we_i, m0_cyc_i, m0_stb_i, m0_dat_i,
        input  m0_ack_o, m0_err_o, m0_dat_o,
        output m1_adr_i, m1_we_i, m1_cyc_i, m1_stb_i, m1_dat_i,
        input  m1_ack_o, m1_err_o, m1_dat_o,
        input  s_adr_o, s_we_o, s_cyc_o, s_stb_o, s_dat_o,
        output s_ack_i, s_dat_i,
        input  gnt_o
    );
endinterface

// File: rtl/s16x4_bus_arbiter.sv
// Two-master round-robin arbiter onto one 16-bit slave bus; grant one clock after cyc, bus muxed combinationally.
// Non-owner stalls (no ack/err) until the owner drops cyc; owner stalled TIMEOUT strobed cycles gets a one-cycle err.
module s16x4_bus_arbiter #(
    parameter int TIMEOUT = 15
) (
    input  logic                 clk_i,
    input  logic                 res_i,
    s16x4_bus_arbiter_if.slave   bus
);
    localparam logic [7:0] TMO = 8'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t     state_q, state_d;
    logic       last_q, last_d;      // 1 = m1 owned last, so m0 wins the next tie
    logic [7:0] cnt_q, cnt_d;

    logic       own0, own1, own_cyc, tmo;
    logic [1:0] own_stb;

    assign own0    = (state_q == OWN0);
    assign own1    = (state_q == OWN1);
    assign own_cyc = (own0 & bus.m0_cyc_i) | (own1 & bus.m1_cyc_i);
    assign own_stb = own0 ? bus.m0_stb_i : (own1 ? bus.m1_stb_i : 2'b00);
    assign tmo     = own_cyc && (cnt_q == TMO);

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (bus.m0_cyc_i && bus.m1_cyc_i) state_d = last_q ? OWN0 : OWN1;
                else if (bus.m0_cyc_i)            state_d = OWN0;
                else if (bus.m1_cyc_i)            state_d = OWN1;
            end
            OWN0: if (!bus.m0_cyc_i) begin
                last_d  = 1'b0;
                state_d = bus.m1_cyc_i ? OWN1 : IDLE;
            end
            OWN1: if (!bus.m1_cyc_i) begin
                last_d  = 1'b1;
                state_d = bus.m0_cyc_i ? OWN0 : IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Counter restarts on any progress, idle strobe, timeout or ownership change.
        if (state_d != state_q || tmo || bus.s_ack_i || !own_cyc || own_stb == 2'b00)
            cnt_d = 8'd0;
        else
            cnt_d = cnt_q + 8'd1;
    end

    always_ff @(posedge clk_i or negedge res_i) begin
        if (!res_i) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        bus.s_adr_o = '0;
        bus.s_we_o  = 1'b0;
        bus.s_cyc_o = 1'b0;
        bus.s_stb_o = 2'b00;
        bus.s_dat_o = '0;
        if (own0) begin
            bus.s_adr_o = bus.m0_adr_i;
            bus.s_we_o  = bus.m0_we_i;
            bus.s_cyc_o = bus.m0_cyc_i;
            bus.s_stb_o = bus.m0_stb_i;
            bus.s_dat_o = bus.m0_dat_i;
        end else if (own1) begin
            bus.s_adr_o = bus.m1_adr_i;
            bus.s_we_o  = bus.m1_we_i;
            bus.s_cyc_o = bus.m1_cyc_i;
            bus.s_stb_o = bus.m1_stb_i;
            bus.s_dat_o = bus.m1_dat_i;
        end
    end

    assign bus.m0_ack_o = bus.s_ack_i & own0 & bus.m0_cyc_i & ~tmo;
    assign bus.m1_ack_o = bus.s_ack_i & own1 & bus.m1_cyc_i & ~tmo;
    assign bus.m0_err_o = own0 & tmo;
    assign bus.m1_err_o = own1 & tmo;
    assign bus.m0_dat_o = bus.s_dat_i;
    assign bus.m1_dat_o = bus.s_dat_i;
    assign bus.gnt_o    = {own1, own0};
endmodule

// File: tb/tb_s16x4_bus_arbiter.sv
// Directed bench for s16x4_bus_arbiter: vector table for arbitration/handover plus hand sequences
// for held-bus idle, timeout pulses with ack suppression, and asynchronous reset mid-transfer.
module tb_s16x4_bus_arbiter;
    localparam logic [14:0] A0 = 15'h7FF8;
    localparam logic [14:0] A1 = 15'h1234;
    localparam logic [15:0] D0 = 16'hA5A5;
    localparam logic [15:0] D1 = 16'h5A5A;

    logic clk = 1'b0;
    logic res_n;
    always #5 clk = ~clk;

    s16x4_bus_arbiter_if bus();

    s16x4_bus_arbiter #(.TIMEOUT(15)) dut (
        .clk_i (clk),
        .res_i (res_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] cur_sdat;

    typedef struct {
        logic       m0c;
        logic [1:0] m0s;
        logic       m1c;
        logic [1:0] m1s;
        logic       ack;
        logic [1:0] gnt;
        logic       scyc;
        logic       m0ack;
        logic       m1ack;
    } vec_t;

    vec_t tbl[17];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic m0c, input logic [1:0] m0s, input logic m1c,
                         input logic [1:0] m1s, input logic ack, input logic [15:0] sdat);
        bus.m0_cyc_i = m0c;
        bus.m0_stb_i = m0s;
        bus.m1_cyc_i = m1c;
        bus.m1_stb_i = m1s;
        bus.s_ack_i  = ack;
        bus.s_dat_i  = sdat;
        cur_sdat     = sdat;
    endtask

    task automatic check_bus(input string tag, input logic [1:0] eg, input logic escyc,
                             input logic em0a, input logic em1a, input logic em0e, input logic em1e);
        logic [14:0] eadr;
        logic [15:0] edat;
        logic [1:0]  estb;
        logic        ewe;
        eadr = 15'h0; edat = 16'h0; estb = 2'b00; ewe = 1'b0;
        if (eg == 2'b01) begin
            eadr = A0; edat = D0; estb = bus.m0_stb_i; ewe = 1'b1;
        end else if (eg == 2'b10) begin
            eadr = A1; edat = D1; estb = bus.m1_stb_i; ewe = 1'b0;
        end
        chk({tag, ".gnt"},    32'(bus.gnt_o),    32'(eg));
        chk({tag, ".s_cyc"},  32'(bus.s_cyc_o),  32'(escyc));
        chk({tag, ".s_adr"},  32'(bus.s_adr_o),  32'(eadr));
        chk({tag, ".s_stb"},  32'(bus.s_stb_o),  32'(estb));
        chk({tag, ".s_we"},   32'(bus.s_we_o),   32'(ewe));
        chk({tag, ".s_dat"},  32'(bus.s_dat_o),  32'(edat));
        chk({tag, ".m0_ack"}, 32'(bus.m0_ack_o), 32'(em0a));
        chk({tag, ".m1_ack"}, 32'(bus.m1_ack_o), 32'(em1a));
        chk({tag, ".m0_err"}, 32'(bus.m0_err_o), 32'(em0e));
        chk({tag, ".m1_err"}, 32'(bus.m1_err_o), 32'(em1e));
        chk({tag, ".m0_dat"}, 32'(bus.m0_dat_o), 32'(cur_sdat));
        chk({tag, ".m1_dat"}, 32'(bus.m1_dat_o), 32'(cur_sdat));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //            m0c   m0s    m1c   m1s    ack  | gnt    scyc  m0ack m1ack
        tbl[0]  = '{1'b1, 2'd3, 1'b1, 2'd3, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 2'd3, 1'b1, 2'd3, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 2'd3, 1'b1, 2'd3, 1'b1, 2'd1, 1'b1, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 2'd3, 1'b1, 2'd3, 1'b1, 2'd1, 1'b1, 1'b1, 1'b0};
        tbl[4]  = '{1'b1, 2'd3, 1'b1, 2'd3, 1'b1, 2'd1, 1'b1, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 2'd3, 1'b1, 2'd3, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 2'd3, 1'b1, 2'd3, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 2'd3, 1'b1, 2'd3, 1'b1, 2'd2, 1'b1, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, 2'd3, 1'b0, 2'd3, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 2'd3, 1'b1, 2'd3, 1'b1, 2'd1, 1'b1, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 2'd3, 1'b0, 2'd3, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 2'd3, 1'b1, 2'd3, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 2'd3, 1'b1, 2'd3, 1'b1, 2'd2, 1'b1, 1'b0, 1'b1};
        tbl[13] = '{1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0};
        tbl[15] = '{1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};
        tbl[16] = '{1'b1, 2'd0, 1'b1, 2'd3, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0};

        bus.m0_adr_i = A0; bus.m0_dat_i = D0; bus.m0_we_i = 1'b1;
        bus.m1_adr_i = A1; bus.m1_dat_i = D1; bus.m1_we_i = 1'b0;
        drive(1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 16'hBEEF);
        res_n = 1'b0;
        #12;
        check_bus("reset", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        res_n = 1'b1;
        tick();

        foreach (tbl[i]) begin
            drive(tbl[i].m0c, tbl[i].m0s, tbl[i].m1c, tbl[i].m1s, tbl[i].ack, 16'hC000 + 16'(i));
            #2;
            check_bus($sformatf("v%0d", i), tbl[i].gnt, tbl[i].scyc, tbl[i].m0ack, tbl[i].m1ack, 1'b0, 1'b0);
            tick();
        end

        // Held bus with stb=00: no counting, no err, grant kept even with m1 waiting.
        for (int k = 0; k < 20; k++) begin
            drive(1'b1, 2'd0, 1'b1, 2'd3, 1'b0, 16'h0100 + 16'(k));
            #2;
            check_bus($sformatf("hold%0d", k), 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
        end

        drive(1'b0, 2'd0, 1'b1, 2'd3, 1'b0, 16'h0200);
        #2;
        check_bus("handover", 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();

        // m1 stalled: err at 15 stalled cycles, again 15 later with s_ack high and ack withheld.
        for (int k = 0; k < 34; k++) begin
            drive(1'b1, 2'd3, 1'b1, 2'd3, (k >= 31), 16'h0300 + 16'(k));
            #2;
            check_bus($sformatf("tmo%0d", k), 2'd2, 1'b1, 1'b0, (k >= 32), 1'b0, (k == 15 || k == 31));
            tick();
        end

        drive(1'b1, 2'd3, 1'b1, 2'd3, 1'b0, 16'h0400);
        #2;
        check_bus("pre_rst", 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #1 res_n = 1'b0;
        #1;
        check_bus("in_rst", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 2'd0, 1'b1, 2'd3, 1'b0, 16'h0500);
        #1 res_n = 1'b1;
        #1;
        check_bus("post_rst_idle", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        #2;
        check_bus("post_rst_gnt", 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
